// File: rtl/mem_arbiter.sv
// mem_arbiter: data-first fetch/data arbiter sharing one single-port RAM with fetch anti-starvation; define ARB_STATS_EN for grant/stall counters
module mem_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_i_req,
    input  logic [31:0] i_i_addr,
    output logic        o_i_gnt,
    output logic        o_i_rvalid,
    output logic [15:0] o_i_rdata,
    input  logic [1:0]  i_d_do,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic        o_d_gnt,
    output logic        o_d_rvalid,
    output logic [31:0] o_d_rdata,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic        o_stall
`ifdef ARB_STATS_EN
    ,
    output logic [31:0] o_stat_i_cnt,
    output logic [31:0] o_stat_d_cnt,
    output logic [31:0] o_stat_stall_cnt
`endif
);
    // state bits double as the registered rvalid outputs
    typedef enum logic [1:0] {IDLE = 2'b00, WAIT_I = 2'b01, WAIT_D = 2'b10} state_t;
    state_t     state;
    logic [3:0] streak;
    logic       i_half;
    logic       d_rd, d_wr, d_pend, force_i;
    logic       unused;
    assign d_rd    = i_d_do == 2'b01;
    assign d_wr    = i_d_do == 2'b10;
    assign d_pend  = d_rd | d_wr;
    assign force_i = i_i_req & (streak == 4'(MAX_D_STREAK));
    assign o_d_gnt = ~i_rst & d_pend & ~force_i;
    assign o_i_gnt = ~i_rst & i_i_req & ~o_d_gnt;
    assign o_mem_en    = o_i_gnt | o_d_gnt;
    assign o_mem_we    = o_d_gnt & d_wr;
    assign o_mem_addr  = o_d_gnt ? {i_d_addr[31:2], 2'b00} : o_i_gnt ? {i_i_addr[31:2], 2'b00} : '0;
    assign o_mem_wdata = o_mem_we ? i_d_wdata : '0;
    assign o_stall     = ~i_rst & ((i_i_req & ~o_i_gnt) | (d_pend & ~o_d_gnt));
    assign o_i_rvalid  = state[0];
    assign o_d_rvalid  = state[1];
    assign o_i_rdata   = o_i_rvalid ? (i_half ? i_mem_rdata[31:16] : i_mem_rdata[15:0]) : '0;
    assign o_d_rdata   = o_d_rvalid ? i_mem_rdata : '0;
    assign unused      = ^{i_i_addr[0], i_d_addr[1:0]};
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            streak <= '0;
            i_half <= 1'b0;
        end else begin
            state <= o_i_gnt ? WAIT_I : (o_d_gnt & d_rd) ? WAIT_D : IDLE;
            if (o_i_gnt)
                i_half <= i_i_addr[1];
            if (o_i_gnt | ~i_i_req)
                streak <= '0;
            else if (o_d_gnt && streak != 4'(MAX_D_STREAK))
                streak <= streak + 4'd1;
        end
    end
`ifdef ARB_STATS_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stat_i_cnt     <= '0;
            o_stat_d_cnt     <= '0;
            o_stat_stall_cnt <= '0;
        end else begin
            o_stat_i_cnt     <= o_stat_i_cnt + 32'(o_i_gnt);
            o_stat_d_cnt     <= o_stat_d_cnt + 32'(o_d_gnt);
            o_stat_stall_cnt <= o_stat_stall_cnt + 32'(o_stall);
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, directed corner sequences and random traffic against a reference model
module tb_mem_arbiter;
    localparam int MAXS = 4;
    logic        clk = 0, rst = 1;
    logic        i_req = 0;
    logic [31:0] i_addr = 0;
    logic        o_i_gnt, o_i_rvalid;
    logic [15:0] o_i_rdata;
    logic [1:0]  d_do = 0;
    logic [31:0] d_addr = 0, d_wdata = 0;
    logic        o_d_gnt, o_d_rvalid;
    logic [31:0] o_d_rdata;
    logic        o_mem_en, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata, mem_rdata;
    logic        o_stall;
`ifdef ARB_STATS_EN
    logic [31:0] st_i, st_d, st_s;
`endif
    mem_arbiter #(.MAX_D_STREAK(MAXS)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_i_req(i_req), .i_i_addr(i_addr), .o_i_gnt(o_i_gnt), .o_i_rvalid(o_i_rvalid), .o_i_rdata(o_i_rdata),
        .i_d_do(d_do), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(mem_rdata), .o_stall(o_stall)
`ifdef ARB_STATS_EN
        , .o_stat_i_cnt(st_i), .o_stat_d_cnt(st_d), .o_stat_stall_cnt(st_s)
`endif
    );
    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic [31:0] shadow [256];
    always @(posedge clk)
        if (o_mem_en) begin
            if (o_mem_we) mem[o_mem_addr[9:2]] <= o_mem_wdata;
            else mem_rdata <= mem[o_mem_addr[9:2]];
        end

    int vectors = 0, miscompares = 0;
    int streak = 0;
    bit egi, egd, exp_irv, exp_drv;
    logic [15:0] exp_ird;
    logic [31:0] exp_drd;

    typedef struct {
        logic i_gnt, d_gnt, stall, mem_en, mem_we, i_rv, d_rv;
        logic [31:0] mem_addr, d_rdata;
        logic [15:0] i_rdata;
    } snap_t;
    snap_t snap;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        streak = 0; exp_irv = 0; exp_drv = 0; egi = 0; egd = 0;
    endtask

    // one cycle: outputs checked at negedge against the model, model advanced at posedge
    task automatic step();
        bit dp;
        logic [31:0] ea;
        @(negedge clk);
        dp  = (d_do == 2'd1) || (d_do == 2'd2);
        egd = dp && !(i_req && streak == MAXS);
        egi = i_req && !egd;
        ea  = egd ? (d_addr & ~32'd3) : (i_addr & ~32'd3);
        snap = '{o_i_gnt, o_d_gnt, o_stall, o_mem_en, o_mem_we, o_i_rvalid, o_d_rvalid, o_mem_addr, o_d_rdata, o_i_rdata};
        chk("i_gnt", o_i_gnt, egi);
        chk("d_gnt", o_d_gnt, egd);
        chk("stall", o_stall, (i_req && !egi) || (dp && !egd));
        chk("mem_en", o_mem_en, egi || egd);
        chk("mem_we", o_mem_we, egd && d_do == 2'd2);
        if (egi || egd) chk("mem_addr", o_mem_addr, ea);
        chk("mem_wdata", o_mem_wdata, (egd && d_do == 2'd2) ? d_wdata : 0);
        chk("i_rvalid", o_i_rvalid, exp_irv);
        chk("d_rvalid", o_d_rvalid, exp_drv);
        chk("i_rdata", o_i_rdata, exp_irv ? exp_ird : 16'h0);
        chk("d_rdata", o_d_rdata, exp_drv ? exp_drd : 0);
        @(posedge clk);
        if (egd && d_do == 2'd2) shadow[d_addr[9:2]] = d_wdata;
        exp_irv = egi;
        exp_drv = egd && d_do == 2'd1;
        if (egi) exp_ird = i_addr[1] ? shadow[i_addr[9:2]][31:16] : shadow[i_addr[9:2]][15:0];
        if (exp_drv) exp_drd = shadow[d_addr[9:2]];
        if (egi || !i_req) streak = 0;
        else if (egd && streak < MAXS) streak++;
        #1;
    endtask

    task automatic idle();
        i_req = 0; d_do = 0;
        step();
    endtask

    task automatic do_reset();
        rst = 1; i_req = 0; d_do = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    typedef struct {
        logic       req;
        logic [1:0] dop;
        logic       e_i, e_d, e_stall, e_we;
    } vec_t;
    vec_t tbl [8];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            shadow[i] = mem[i];
        end
        tbl[0] = '{0, 2'd0, 0, 0, 0, 0};
        tbl[1] = '{1, 2'd0, 1, 0, 0, 0};
        tbl[2] = '{0, 2'd1, 0, 1, 0, 0};
        tbl[3] = '{0, 2'd2, 0, 1, 0, 1};
        tbl[4] = '{0, 2'd3, 0, 0, 0, 0};
        tbl[5] = '{1, 2'd1, 0, 1, 1, 0};
        tbl[6] = '{1, 2'd2, 0, 1, 1, 1};
        tbl[7] = '{1, 2'd3, 1, 0, 0, 0};
        #1;
        chk("reset_gnt", {o_i_gnt, o_d_gnt, o_mem_en, o_stall}, 0);
        do_reset();
        model_reset();

        for (int k = 0; k < 8; k++) begin
            i_req = tbl[k].req; i_addr = 32'($urandom_range(0, 511)) << 1;
            d_do = tbl[k].dop; d_addr = 32'($urandom_range(0, 1023)); d_wdata = $urandom;
            step();
            chk("tbl_i_gnt", snap.i_gnt, tbl[k].e_i);
            chk("tbl_d_gnt", snap.d_gnt, tbl[k].e_d);
            chk("tbl_stall", snap.stall, tbl[k].e_stall);
            chk("tbl_we", snap.mem_we, tbl[k].e_we);
            idle();
        end

        // fetch only, two halves of one word
        mem[4] = 32'hBEEFCAFE; shadow[4] = 32'hBEEFCAFE;
        i_req = 1; i_addr = 32'h10; step();
        chk("fo_gnt0", snap.i_gnt, 1); chk("fo_addr0", snap.mem_addr, 32'h10);
        i_addr = 32'h12; step();
        chk("fo_gnt1", snap.i_gnt, 1); chk("fo_addr1", snap.mem_addr, 32'h10);
        chk("fo_rv1", snap.i_rv, 1); chk("fo_rd1", snap.i_rdata, 16'hCAFE);
        i_req = 0; step();
        chk("fo_rv2", snap.i_rv, 1); chk("fo_rd2", snap.i_rdata, 16'hBEEF);
        idle();

        // conflict, from a fresh reset so the stats start at zero
        do_reset();
        mem[16] = 32'hA5A51234; shadow[16] = 32'hA5A51234;
        i_req = 1; i_addr = 0; d_do = 2'd1; d_addr = 32'h40; step();
        chk("cf_d_gnt", snap.d_gnt, 1); chk("cf_i_gnt", snap.i_gnt, 0); chk("cf_stall", snap.stall, 1);
        d_do = 0; step();
        chk("cf_d_rv", snap.d_rv, 1); chk("cf_d_rd", snap.d_rdata, 32'hA5A51234); chk("cf_i_gnt1", snap.i_gnt, 1);
        i_req = 0; step();
        chk("cf_i_rv", snap.i_rv, 1);
`ifdef ARB_STATS_EN
        chk("st_i", st_i, 1); chk("st_d", st_d, 1); chk("st_stall", st_s, 1);
`endif
        idle();

        // starvation: held fetch vs continuous data reads
        i_req = 1; i_addr = 32'h100; d_do = 2'd1;
        for (int k = 0; k < 15; k++) begin
            d_addr = 32'($urandom_range(0, 1023));
            step();
            chk("starve_i", snap.i_gnt, (k % 5) == 4);
            chk("starve_d", snap.d_gnt, (k % 5) != 4);
        end
        idle();

        // write then fetch of the same word
        d_do = 2'd2; d_addr = 32'h20; d_wdata = 32'h12345678; i_req = 1; i_addr = 32'h22; step();
        chk("wf_we", snap.mem_we, 1); chk("wf_i_gnt0", snap.i_gnt, 0);
        d_do = 0; step();
        chk("wf_i_gnt1", snap.i_gnt, 1);
        i_req = 0; step();
        chk("wf_rd", snap.i_rdata, 16'h1234);
        idle();

        // reset while a data read is in flight
        d_do = 2'd1; d_addr = 32'h44; step();
        chk("rr_gnt", snap.d_gnt, 1);
        rst = 1; d_do = 0;
        #1;
        chk("rr_outs", {o_i_gnt, o_d_gnt, o_i_rvalid, o_d_rvalid, o_mem_en, o_mem_we, o_stall}, 0);
        chk("rr_data", {o_mem_addr, o_mem_wdata, o_d_rdata, o_i_rdata}, 0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        step();
        chk("rr_drv", snap.d_rv, 0); chk("rr_en", snap.mem_en, 0); chk("rr_stall", snap.stall, 0);

        // random traffic, requests held until granted
        for (int k = 0; k < 3000; k++) begin
            if (egi || !i_req) begin
                i_req = $urandom_range(0, 2) != 0;
                i_addr = 32'($urandom_range(0, 511)) << 1;
            end
            if (egd || !(d_do == 2'd1 || d_do == 2'd2)) begin
                d_do = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : ($urandom_range(0, 1) ? 2'd1 : 2'd2);
                d_addr = 32'($urandom_range(0, 1023));
                d_wdata = $urandom;
            end
            step();
        end
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
